// File: rtl/kftvga_vram_ctrl.sv
// KFTVGA single-clock VRAM: byte-wide CPU port and wide video fetch port sharing one memory.
// Define KFTVGA_VRAM_CLEAR_EN to build the whole-memory fill engine.
module kftvga_vram_ctrl #(
    parameter int CPU_ADDR_WIDTH   = 14,
    parameter int RATIO_LOG2       = 1,
    localparam int VIDEO_WIDTH      = 8 << RATIO_LOG2,
    localparam int VIDEO_ADDR_WIDTH = CPU_ADDR_WIDTH - RATIO_LOG2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [CPU_ADDR_WIDTH-1:0]   address,
    input  logic                        write_vram,
    input  logic                        read_vram,
    input  logic [7:0]                  vram_data_in,
    output logic                        vram_ready,
    output logic [7:0]                  vram_data_out,
    output logic                        vram_read_valid,
    input  logic                        video_read,
    input  logic [VIDEO_ADDR_WIDTH-1:0] video_address,
    output logic [VIDEO_WIDTH-1:0]      video_data_out,
    output logic                        video_data_valid,
    input  logic                        clear_start,
    input  logic [7:0]                  clear_value,
    output logic                        clear_busy
);
    localparam int LANES = 1 << RATIO_LOG2;
    localparam int DEPTH = 1 << VIDEO_ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_CLEAR} state_t;

    state_t                      r_state;
    state_t                      w_next_state;
    logic [CPU_ADDR_WIDTH-1:0]   r_pend_addr;
    logic [7:0]                  r_pend_data;
    logic                        r_pend_write;
    logic [VIDEO_WIDTH-1:0]      r_mem [0:DEPTH-1];
    logic [VIDEO_WIDTH-1:0]      r_video_data;
    logic                        r_video_valid;
    logic [7:0]                  r_cpu_data;
    logic                        r_cpu_valid;

    logic                        w_req;
    logic                        w_cpu_exec;
    logic                        w_clr_exec;
    logic                        w_clr_go;
    logic                        w_mem_we;
    logic [VIDEO_ADDR_WIDTH-1:0] w_mem_waddr;
    logic [VIDEO_WIDTH-1:0]      w_mem_wdata;
    logic [LANES-1:0]            w_mem_be;
    logic [VIDEO_ADDR_WIDTH-1:0] w_mem_raddr;
    logic [VIDEO_WIDTH-1:0]      w_mem_rword;
    logic [VIDEO_ADDR_WIDTH-1:0] w_pend_word;
    logic [RATIO_LOG2-1:0]       w_pend_lane;

    // Lane decode assumes RATIO_LOG2 >= 1 (video word at least two bytes).
    assign w_pend_word = r_pend_addr[CPU_ADDR_WIDTH-1:RATIO_LOG2];
    assign w_pend_lane = r_pend_addr[RATIO_LOG2-1:0];
    assign w_req       = (write_vram | read_vram) && (r_state == S_IDLE);
    assign w_cpu_exec  = (r_state == S_PENDING) && !video_read;

`ifdef KFTVGA_VRAM_CLEAR_EN
    logic [VIDEO_ADDR_WIDTH-1:0] r_clr_cnt;
    logic [7:0]                  r_clr_value;

    // A CPU request accepted in the same cycle wins; that clear_start is dropped.
    assign w_clr_go   = (r_state == S_IDLE) && !w_req && clear_start;
    assign w_clr_exec = (r_state == S_CLEAR) && !video_read;
    assign clear_busy = (r_state == S_CLEAR);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_clr_cnt   <= '0;
            r_clr_value <= '0;
        end else if (w_clr_go) begin
            r_clr_cnt   <= '0;
            r_clr_value <= clear_value;
        end else if (w_clr_exec) begin
            r_clr_cnt   <= r_clr_cnt + 1'b1;
        end
    end
`else
    logic w_unused_clear;

    assign w_unused_clear = &{1'b0, clear_start, clear_value};
    assign w_clr_go       = 1'b0;
    assign w_clr_exec     = 1'b0;
    assign clear_busy     = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req)         w_next_state = S_PENDING;
                else if (w_clr_go) w_next_state = S_CLEAR;
            end
            S_PENDING: begin
                if (!video_read) w_next_state = S_IDLE;
            end
            S_CLEAR: begin
`ifdef KFTVGA_VRAM_CLEAR_EN
                if (w_clr_exec && (r_clr_cnt == '1)) w_next_state = S_IDLE;
`else
                w_next_state = S_IDLE;
`endif
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
            r_pend_write <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_req) begin
                r_pend_addr  <= address;
                r_pend_data  <= vram_data_in;
                r_pend_write <= write_vram;
            end
        end
    end

    // Write port: a CPU byte lane or a full clear word, never both in one cycle.
    always_comb begin
        w_mem_we                 = 1'b0;
        w_mem_waddr              = w_pend_word;
        w_mem_wdata              = {LANES{r_pend_data}};
        w_mem_be                 = '0;
        w_mem_be[w_pend_lane]    = 1'b1;
        if (w_cpu_exec && r_pend_write) begin
            w_mem_we = reset_n;
        end
`ifdef KFTVGA_VRAM_CLEAR_EN
        if (w_clr_exec) begin
            w_mem_we    = reset_n;
            w_mem_waddr = r_clr_cnt;
            w_mem_wdata = {LANES{r_clr_value}};
            w_mem_be    = '1;
        end
`endif
    end

    // NOTE: the memory array has no reset; clearing it is the fill engine's job, and a
    // reset term here would stop it mapping onto block RAM.
    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_mem_we && w_mem_be[i]) begin
                r_mem[w_mem_waddr][i*8 +: 8] <= w_mem_wdata[i*8 +: 8];
            end
        end
    end

    assign w_mem_raddr = video_read ? video_address : w_pend_word;
    assign w_mem_rword = r_mem[w_mem_raddr];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_video_data  <= '0;
            r_video_valid <= 1'b0;
            r_cpu_data    <= '0;
            r_cpu_valid   <= 1'b0;
        end else begin
            r_video_valid <= video_read;
            if (video_read) begin
                r_video_data <= w_mem_rword;
            end
            r_cpu_valid <= w_cpu_exec && !r_pend_write;
            if (w_cpu_exec && !r_pend_write) begin
                r_cpu_data <= w_mem_rword[{w_pend_lane, 3'b000} +: 8];
            end
        end
    end

    assign vram_ready       = (r_state == S_IDLE);
    assign vram_data_out    = r_cpu_data;
    assign vram_read_valid  = r_cpu_valid;
    assign video_data_out   = r_video_data;
    assign video_data_valid = r_video_valid;

endmodule

// File: tb/tb_kftvga_vram_ctrl.sv
// Scoreboard bench for kftvga_vram_ctrl; with KFTVGA_VRAM_CLEAR_EN a second small
// instance (6-bit address, 32-bit words) exercises the fill engine.
module tb_kftvga_vram_ctrl;
    localparam int AW  = 14;
    localparam int R   = 1;
    localparam int VW  = 8 << R;
    localparam int VAW = AW - R;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [AW-1:0]  address = '0;
    logic           write_vram = 1'b0;
    logic           read_vram = 1'b0;
    logic [7:0]     vram_data_in = '0;
    logic           vram_ready;
    logic [7:0]     vram_data_out;
    logic           vram_read_valid;
    logic           video_read = 1'b0;
    logic [VAW-1:0] video_address = '0;
    logic [VW-1:0]  video_data_out;
    logic           video_data_valid;
    logic           clear_start = 1'b0;
    logic [7:0]     clear_value = '0;
    logic           clear_busy;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t rd_q[$];
    exp_t vd_q[$];
    exp_t rd_e;
    exp_t vd_e;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    kftvga_vram_ctrl #(.CPU_ADDR_WIDTH(AW), .RATIO_LOG2(R)) u_dut (
        .clock(clock), .reset_n(reset_n), .address(address),
        .write_vram(write_vram), .read_vram(read_vram), .vram_data_in(vram_data_in),
        .vram_ready(vram_ready), .vram_data_out(vram_data_out),
        .vram_read_valid(vram_read_valid), .video_read(video_read),
        .video_address(video_address), .video_data_out(video_data_out),
        .video_data_valid(video_data_valid), .clear_start(clear_start),
        .clear_value(clear_value), .clear_busy(clear_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (vram_read_valid) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", vram_read_valid, 1'b0);
            end else begin
                rd_e = rd_q.pop_front();
                check("rd_data", vram_data_out, rd_e.data);
                check("rd_cycle", cyc, rd_e.cyc);
            end
        end
        if (video_data_valid) begin
            if (vd_q.size() == 0) begin
                check("vd_unexpected", video_data_valid, 1'b0);
            end else begin
                vd_e = vd_q.pop_front();
                check("vd_data", video_data_out, vd_e.data);
                check("vd_cycle", cyc, vd_e.cyc);
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!vram_ready && n < 50) begin
            tick();
            n++;
        end
        check(name, vram_ready, 1'b1);
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
        wait_ready("wr_ready");
        address      = a;
        vram_data_in = d;
        write_vram   = 1'b1;
        tick();
        write_vram   = 1'b0;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, input logic [7:0] d, input int extra);
        wait_ready("rd_ready");
        address   = a;
        read_vram = 1'b1;
        rd_q.push_back('{data: 32'(d), cyc: cyc + 2 + extra});
        tick();
        read_vram = 1'b0;
    endtask

    task automatic vid(input logic [VAW-1:0] a, input logic [VW-1:0] d);
        video_read    = 1'b1;
        video_address = a;
        vd_q.push_back('{data: 32'(d), cyc: cyc + 1});
        tick();
        video_read    = 1'b0;
    endtask

`ifdef KFTVGA_VRAM_CLEAR_EN
    logic        s_ready, s_rd_valid, s_vread = 1'b0, s_vvalid, s_cstart = 1'b0, s_busy;
    logic [7:0]  s_rd_data, s_cvalue = '0;
    logic [3:0]  s_vaddr = '0;
    logic [31:0] s_vdata;
    exp_t        sq[$];
    exp_t        s_e;

    kftvga_vram_ctrl #(.CPU_ADDR_WIDTH(6), .RATIO_LOG2(2)) u_small (
        .clock(clock), .reset_n(reset_n), .address(6'd0),
        .write_vram(1'b0), .read_vram(1'b0), .vram_data_in(8'd0),
        .vram_ready(s_ready), .vram_data_out(s_rd_data),
        .vram_read_valid(s_rd_valid), .video_read(s_vread),
        .video_address(s_vaddr), .video_data_out(s_vdata),
        .video_data_valid(s_vvalid), .clear_start(s_cstart),
        .clear_value(s_cvalue), .clear_busy(s_busy)
    );

    always @(negedge clock) begin
        if (s_rd_valid) check("s_rd_unexpected", s_rd_valid, 1'b0);
        if (s_vvalid) begin
            if (sq.size() == 0) begin
                check("s_vd_unexpected", s_vvalid, 1'b0);
            end else begin
                s_e = sq.pop_front();
                check("s_vd_data", s_vdata, s_e.data);
                check("s_vd_cycle", cyc, s_e.cyc);
            end
        end
    end

    task automatic svid(input logic [3:0] a, input logic [31:0] d);
        s_vread = 1'b1;
        s_vaddr = a;
        sq.push_back('{data: d, cyc: cyc + 1});
        tick();
        s_vread = 1'b0;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("rst_ready", vram_ready, 1'b1);
        check("rst_rd_data", vram_data_out, 8'h00);
        check("rst_rd_valid", vram_read_valid, 1'b0);
        check("rst_vd_data", video_data_out, 16'h0000);
        check("rst_vd_valid", video_data_valid, 1'b0);
        check("rst_busy", clear_busy, 1'b0);
        reset_n = 1'b1;
        tick();

        // Second request while busy must be dropped; next op allowed two cycles later.
        cpu_write(14'h0020, 8'h11);
        check("ready_low_n1", vram_ready, 1'b0);
        address      = 14'h0020;
        vram_data_in = 8'h99;
        write_vram   = 1'b1;
        tick();
        write_vram   = 1'b0;
        check("ready_high_n2", vram_ready, 1'b1);
        cpu_read(14'h0020, 8'h11, 0);

        cpu_write(14'h0001, 8'hA5);
        cpu_write(14'h0000, 8'h3C);
        wait_ready("vd_ready");
        vid(13'h0000, 16'hA53C);

        // CPU read stalled by four video cycles.
        wait_ready("stall_ready");
        address   = 14'h0001;
        read_vram = 1'b1;
        rd_q.push_back('{data: 32'h0000_00A5, cyc: cyc + 6});
        tick();
        read_vram = 1'b0;
        for (int i = 0; i < 4; i++) begin
            video_read    = 1'b1;
            video_address = 13'h0000;
            vd_q.push_back('{data: 32'h0000_A53C, cyc: cyc + 1});
            check("ready_stall", vram_ready, 1'b0);
            tick();
        end
        video_read = 1'b0;
        check("ready_exec", vram_ready, 1'b0);
        tick();
        check("ready_after_stall", vram_ready, 1'b1);

        // Write and read together is a write only.
        wait_ready("wr_rd_ready");
        address      = 14'h0010;
        vram_data_in = 8'h77;
        write_vram   = 1'b1;
        read_vram    = 1'b1;
        tick();
        write_vram   = 1'b0;
        read_vram    = 1'b0;
        repeat (3) tick();
        cpu_read(14'h0010, 8'h77, 0);

        cpu_write(14'h0001, 8'h5A);
        cpu_read(14'h0001, 8'h5A, 0);
        wait_ready("vd2_ready");
        vid(13'h0000, 16'h5A3C);

        cpu_write(14'h3FFF, 8'hC3);
        cpu_write(14'h3FFE, 8'h81);
        wait_ready("vd3_ready");
        vid(13'h1FFF, 16'hC381);

        // Reset while a write is pending drops it.
        wait_ready("rst_pend_ready");
        address      = 14'h0000;
        vram_data_in = 8'hEE;
        write_vram   = 1'b1;
        tick();
        write_vram   = 1'b0;
        reset_n      = 1'b0;
        tick();
        reset_n      = 1'b1;
        check("rst_pend_ready", vram_ready, 1'b1);
        check("rst_pend_rd_data", vram_data_out, 8'h00);
        repeat (3) tick();
        vid(13'h0000, 16'h5A3C);

`ifndef KFTVGA_VRAM_CLEAR_EN
        clear_value = 8'h00;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("noclr_busy", clear_busy, 1'b0);
            check("noclr_ready", vram_ready, 1'b1);
            tick();
        end
        vid(13'h0000, 16'h5A3C);
        vid(13'h1FFF, 16'hC381);
`else
        begin
            int n = 0;
            s_cvalue = 8'hFF;
            s_cstart = 1'b1;
            tick();
            s_cstart = 1'b0;
            check("clr_ready_low", s_ready, 1'b0);
            while (s_busy && n < 100) begin
                n++;
                tick();
            end
            check("clr_len", n, 16);
            check("clr_ready_back", s_ready, 1'b1);
            for (int w = 0; w < 16; w++) svid(4'(w), 32'hFFFF_FFFF);

            s_cvalue = 8'h00;
            s_cstart = 1'b1;
            tick();
            s_cstart = 1'b0;
            check("clr2_busy", s_busy, 1'b1);
            repeat (5) tick();
            reset_n = 1'b0;
            tick();
            reset_n = 1'b1;
            check("clr2_busy_rst", s_busy, 1'b0);
            for (int w = 0; w < 16; w++) svid(4'(w), (w < 5) ? 32'h0 : 32'hFFFF_FFFF);
        end
`endif

        repeat (3) tick();
        check("rd_q_drain", rd_q.size(), 0);
        check("vd_q_drain", vd_q.size(), 0);
`ifdef KFTVGA_VRAM_CLEAR_EN
        check("s_q_drain", sq.size(), 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/kftvga_vram_ctrl.md
# kftvga_vram_ctrl

Parametrised single-clock VRAM controller for KFTVGA: one inferred memory shared by a byte-wide CPU port and a wide video fetch port. Video reads have absolute priority; CPU accesses are buffered in a one-entry pending register with a ready/valid handshake and execute in video-idle cycles. It sits between the bus interface and the CRTC/pixel fetch, replacing the fixed 8/16-bit dual-clock VRAM. An optional fill engine clears the whole memory to a byte value.

## Interface
- CPU_ADDR_WIDTH, 14, CPU byte-address width; memory holds 2^CPU_ADDR_WIDTH bytes
- RATIO_LOG2, 1, video word = 2^RATIO_LOG2 bytes; VIDEO_WIDTH = 8<<RATIO_LOG2, VIDEO_ADDR_WIDTH = CPU_ADDR_WIDTH-RATIO_LOG2
- clock  in  1  single clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- address  in  CPU_ADDR_WIDTH  CPU byte address
- write_vram  in  1  CPU write request
- read_vram  in  1  CPU read request
- vram_data_in  in  8  CPU write data
- vram_ready  out  1  pending buffer empty; request accepted when (write_vram|read_vram)&vram_ready
- vram_data_out  out  8  CPU read data, held until next read completes
- vram_read_valid  out  1  one-cycle pulse: vram_data_out updated
- video_read  in  1  video fetch strobe
- video_address  in  VIDEO_ADDR_WIDTH  video word address
- video_data_out  out  VIDEO_WIDTH  fetched word, held until next fetch
- video_data_valid  out  1  one-cycle pulse, cycle after video_read
- clear_start  in  1  fill-engine start pulse
- clear_value  in  8  fill byte, sampled with clear_start
- clear_busy  out  1  fill in progress

## Operation
- Byte mapping: word = address>>RATIO_LOG2, lane = address[RATIO_LOG2-1:0]; lane 0 = bits [7:0] (little-endian). CPU write is a single-lane byte-enable write.
- States: IDLE, PENDING, CLEAR.
- IDLE: accepted request captures address/data/op into pending, -> PENDING. write_vram&read_vram together = write only, no read_valid.
- PENDING: vram_ready=0. If video_read=0 this cycle, memory executes the pending op, -> IDLE (vram_ready=1 next cycle). If video_read=1, stall in PENDING.
- Read returns the addressed lane; vram_read_valid pulses the cycle after execution.
- Video: video_read=1 always uses the memory that cycle; read-before-write impossible since CPU never shares the cycle.
- Ordering preserved: one outstanding CPU op; a read after a write to same byte returns new data.
- CLEAR: clear_start in IDLE -> CLEAR, word counter = 0, clear_busy=1, vram_ready=0. Each video-idle cycle writes clear_value to all lanes of counter word, counter++. After last word (2^VIDEO_ADDR_WIDTH-1) written -> IDLE. clear_start in PENDING or CLEAR ignored.
- Memory contents not reset.

## Timing
- Reset values: vram_ready=1, vram_data_out=0, vram_read_valid=0, video_data_out=0, video_data_valid=0, clear_busy=0, state IDLE, pending cleared.
- Reset mid-PENDING drops the op; mid-CLEAR aborts fill (partially cleared memory is legal).
- Video latency: video_read at N -> data/valid at N+1, fixed.
- CPU min latency: accept N, execute N+1, read_valid N+2, vram_ready=1 at N+2. Each video-busy cycle adds one.
- Back-to-back CPU ops without video: one op per 2 cycles.
- Continuous video_read starves CPU and fill indefinitely (CRTC guarantees blanking gaps).
- Clear duration: 2^VIDEO_ADDR_WIDTH video-idle cycles; clear_busy falls the cycle after last write.

## Configuration
- KFTVGA_VRAM_CLEAR_EN defined: fill engine and CLEAR state built as above.
- Undefined: clear_start/clear_value ignored, clear_busy tied 0, no counter; ports remain for a fixed interface.

## Test plan
- Reset: hold reset_n=0 3 cycles -> all outputs at reset values, vram_ready=1.
- Default params: write 0xA5 to 0x0001, 0x3C to 0x0000, video_read addr 0 -> video_data_out=0xA53C at next cycle, valid pulse.
- CPU read of 0x0001 with video_read high 4 cycles after accept -> vram_read_valid at accept+6, data 0xA5; vram_ready low throughout.
- write_vram&read_vram together to 0x0010 data 0x77 -> byte written, no read_valid; request while vram_ready=0 -> not captured.
- With KFTVGA_VRAM_CLEAR_EN, RATIO_LOG2=2, CPU_ADDR_WIDTH=6: clear_start value 0xFF, video idle -> clear_busy 16 cycles, every word reads 0xFFFFFFFF; reset after 5 cycles -> words 0-4 cleared, rest intact.
- Without macro: clear_start -> clear_busy stays 0, memory unchanged.
